// File: rtl/wide_add_sched_pkg.sv
// Shared defaults and FSM state encoding for the wide-operand add scheduler.
package wide_add_pkg;

    localparam int W_DEF       = 16;
    localparam int NWORDS_DEF  = 4;
    localparam int ADD_LAT_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/wide_add_sched_if.sv
// Requester, shared-adder and response signals of the wide add scheduler.
interface wide_add_sched_if
    import wide_add_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int NWORDS = NWORDS_DEF
);
    localparam int N = W * NWORDS;

    logic         req0_valid;
    logic         req0_ready;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic         req1_valid;
    logic         req1_ready;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;

    logic         add_go;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic         add_cin;
    logic [W-1:0] add_sum;
    logic         add_cout;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [N-1:0] rsp_sum;
    logic         rsp_cout;

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  add_go, add_a, add_b, add_cin,
        output add_sum, add_cout,
        input  rsp_valid, rsp_id, rsp_sum, rsp_cout,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        output req0_ready, req1_ready,
        output add_go, add_a, add_b, add_cin,
        input  add_sum, add_cout,
        output rsp_valid, rsp_id, rsp_sum, rsp_cout,
        input  rsp_ready
    );

endinterface

// File: rtl/wide_add_sched_rr_arb2.sv
// Two-input round-robin arbiter; the last winner loses a tie on the next accept.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_reg;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_reg ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Reset pretends requester 1 was served last so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_reg <= 1'b1;
        end else if (accept) begin
            last_reg <= grant[1];
        end
    end

endmodule

// File: rtl/wide_add_sched.sv
// Serialises an N-bit add over a shared W-bit adder, slice by slice, for two
// round-robin requesters; one operation in flight at a time.
module wide_add_sched
    import wide_add_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int NWORDS  = NWORDS_DEF,
    parameter int ADD_LAT = ADD_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    wide_add_sched_if.slave  bus
);

    localparam int N  = W * NWORDS;
    localparam int KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int CW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    localparam logic [KW-1:0] K_LAST   = KW'(NWORDS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ADD_LAT - 1);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] ISSUE = ST_ISSUE;
    localparam logic [1:0] WAIT  = ST_WAIT;
    localparam logic [1:0] DONE  = ST_DONE;

    logic [1:0]    state_reg;
    logic [KW-1:0] k_reg;
    logic [CW-1:0] cnt_reg;
    logic          carry_reg;
    logic          id_reg;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic [W-1:0]  res_reg [NWORDS];

    logic [W-1:0]  a_slice [NWORDS];
    logic [W-1:0]  b_slice [NWORDS];
    logic [N-1:0]  sum_flat;

    logic [1:0]    grant;
    logic          in_idle;
    logic          in_issue;
    logic          in_wait;
    logic          in_done;
    logic          accept;
    logic          sample;

    assign in_idle  = (state_reg == IDLE);
    assign in_issue = (state_reg == ISSUE);
    assign in_wait  = (state_reg == WAIT);
    assign in_done  = (state_reg == DONE);

    // Grant already implies the matching valid, so ready alone marks the accept.
    assign accept = in_idle & (grant[0] | grant[1]);
    assign sample = in_wait & (cnt_reg == CNT_LAST);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({bus.req1_valid, bus.req0_valid}),
        .accept (accept),
        .grant  (grant)
    );

    assign bus.req0_ready = in_idle & grant[0];
    assign bus.req1_ready = in_idle & grant[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            k_reg     <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            id_reg    <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_reg     <= grant[1] ? bus.req1_a : bus.req0_a;
                        b_reg     <= grant[1] ? bus.req1_b : bus.req0_b;
                        id_reg    <= grant[1];
                        k_reg     <= '0;
                        carry_reg <= 1'b0;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_reg   <= '0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (sample) begin
                        carry_reg <= bus.add_cout;
                        if (k_reg == K_LAST) begin
                            state_reg <= DONE;
                        end else begin
                            k_reg     <= k_reg + 1'b1;
                            state_reg <= ISSUE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < NWORDS; gi++) begin : g_slice
        assign a_slice[gi] = a_reg[gi*W +: W];
        assign b_slice[gi] = b_reg[gi*W +: W];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                res_reg[gi] <= '0;
            end else if (accept) begin
                res_reg[gi] <= '0;
            end else if (sample && (k_reg == KW'(gi))) begin
                res_reg[gi] <= bus.add_sum;
            end
        end

        assign sum_flat[gi*W +: W] = res_reg[gi];
    end

    // The adder bus idles at zero so stale slices never leak onto it.
    assign bus.add_go  = in_issue;
    assign bus.add_a   = in_issue ? a_slice[k_reg] : '0;
    assign bus.add_b   = in_issue ? b_slice[k_reg] : '0;
    assign bus.add_cin = in_issue & (k_reg != '0) & carry_reg;

    assign bus.rsp_valid = in_done;
    assign bus.rsp_id    = in_done & id_reg;
    assign bus.rsp_cout  = in_done & carry_reg;
    assign bus.rsp_sum   = in_done ? sum_flat : '0;

endmodule

// File: tb/tb_wide_add_sched.sv
// Scoreboarded directed bench for wide_add_sched, with default and ADD_LAT=1 builds.
`timescale 1ns/1ps
module tb_wide_add_sched;
    import wide_add_pkg::*;

    localparam int W      = 16;
    localparam int NWORDS = 4;
    localparam int N      = W * NWORDS;

    typedef logic [N:0] val_t;
    typedef struct packed {
        logic         id;
        logic [N-1:0] sum;
        logic         cout;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    wide_add_sched_if #(.W(W), .NWORDS(NWORDS)) b0 ();
    wide_add_sched_if #(.W(W), .NWORDS(NWORDS)) b1 ();

    wide_add_sched #(.W(W), .NWORDS(NWORDS), .ADD_LAT(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    wide_add_sched #(.W(W), .NWORDS(NWORDS), .ADD_LAT(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    // Behavioural shared adders, deliberately not reset.
    logic [W:0] pipe0 [2];
    logic [W:0] pipe1;
    always @(posedge clk) begin
        pipe0[0] <= {1'b0, b0.add_a} + {1'b0, b0.add_b} + {{W{1'b0}}, b0.add_cin};
        pipe0[1] <= pipe0[0];
        pipe1    <= {1'b0, b1.add_a} + {1'b0, b1.add_b} + {{W{1'b0}}, b1.add_cin};
    end
    assign b0.add_sum  = pipe0[1][W-1:0];
    assign b0.add_cout = pipe0[1][W];
    assign b1.add_sum  = pipe1[W-1:0];
    assign b1.add_cout = pipe1[W];

    task automatic check(input string name, input val_t act, input val_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor for the default build.
    exp_t         exp_q [$];
    exp_t         e;
    logic         prev_valid = 1'b0;
    logic         prev_ready = 1'b0;
    logic [N-1:0] prev_sum   = '0;
    logic         prev_cout  = 1'b0;
    logic         prev_id    = 1'b0;
    int           acc_cyc    = 0;
    int           hs_cyc     = 0;
    int           issue_idx  = 0;
    logic [3:0]   cin_log    = 4'b0000;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            issue_idx  = 0;
        end else begin
            check("dual_ready", val_t'(b0.req0_ready & b0.req1_ready), val_t'(0));
            if (!b0.add_go)
                check("adder_idle_zero", val_t'({b0.add_a, b0.add_b, b0.add_cin}), val_t'(0));
            else begin
                cin_log[issue_idx[1:0]] = b0.add_cin;
                issue_idx++;
            end
            if (b0.rsp_valid)
                check("ready_in_done", val_t'({b0.req0_ready, b0.req1_ready}), val_t'(0));
            if (b0.rsp_valid && prev_valid && !prev_ready) begin
                check("hold_sum", val_t'(b0.rsp_sum), val_t'(prev_sum));
                check("hold_cout_id", val_t'({b0.rsp_cout, b0.rsp_id}), val_t'({prev_cout, prev_id}));
            end
            if ((b0.req0_valid && b0.req0_ready) || (b0.req1_valid && b0.req1_ready)) begin
                acc_cyc   = cyc;
                issue_idx = 0;
                $display("[TB] accept id=%0d cyc=%0d", b0.req1_ready, cyc);
            end
            if (b0.rsp_valid && !prev_valid)
                check("latency", val_t'(cyc - acc_cyc), val_t'(13));
            if (b0.rsp_valid && b0.rsp_ready) begin
                hs_cyc = cyc;
                $display("[TB] rsp id=%0d sum=0x%h cout=%0d cyc=%0d",
                         b0.rsp_id, b0.rsp_sum, b0.rsp_cout, cyc);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_rsp: got id=%0d sum=0x%h, expected none",
                             b0.rsp_id, b0.rsp_sum);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_id", val_t'(b0.rsp_id), val_t'(e.id));
                    check("rsp_sum", val_t'(b0.rsp_sum), val_t'(e.sum));
                    check("rsp_cout", val_t'(b0.rsp_cout), val_t'(e.cout));
                end
            end
            prev_valid = b0.rsp_valid;
            prev_ready = b0.rsp_ready;
            prev_sum   = b0.rsp_sum;
            prev_cout  = b0.rsp_cout;
            prev_id    = b0.rsp_id;
        end
    end

    task automatic present(input logic id, input logic [N-1:0] a, input logic [N-1:0] b);
        if (id) begin
            b0.req1_valid = 1'b1; b0.req1_a = a; b0.req1_b = b;
        end else begin
            b0.req0_valid = 1'b1; b0.req0_a = a; b0.req0_b = b;
        end
    endtask

    task automatic release_req(input logic id);
        if (id) b0.req1_valid = 1'b0;
        else    b0.req0_valid = 1'b0;
    endtask

    task automatic await_accept(input logic id);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = id ? b0.req1_ready : b0.req0_ready;
        end
        check("accept_timeout", val_t'(got), val_t'(1));
    endtask

    task automatic issue(input logic id, input logic [N-1:0] a, input logic [N-1:0] b);
        @(posedge clk); #1;
        present(id, a, b);
        await_accept(id);
        @(posedge clk); #1;
        release_req(id);
    endtask

    task automatic stream2(input logic id, input logic [N-1:0] a0, input logic [N-1:0] bb0,
                           input logic [N-1:0] a1, input logic [N-1:0] bb1);
        @(posedge clk); #1;
        present(id, a0, bb0);
        await_accept(id);
        @(posedge clk); #1;
        present(id, a1, bb1);
        await_accept(id);
        @(posedge clk); #1;
        release_req(id);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 500) begin
            @(negedge clk);
            i++;
        end
        check("drain_timeout", val_t'(exp_q.size()), val_t'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int     go_cnt;
        int     acc1;
        logic   seen;
        b0.req0_valid = 1'b0; b0.req0_a = '0; b0.req0_b = '0;
        b0.req1_valid = 1'b0; b0.req1_a = '0; b0.req1_b = '0;
        b0.rsp_ready  = 1'b1;
        b1.req0_valid = 1'b0; b1.req0_a = '0; b1.req0_b = '0;
        b1.req1_valid = 1'b0; b1.req1_a = '0; b1.req1_b = '0;
        b1.rsp_ready  = 1'b1;

        #1;
        check("rst_rsp_valid", val_t'(b0.rsp_valid), val_t'(0));
        check("rst_add_bus", val_t'({b0.add_go, b0.add_a, b0.add_b, b0.add_cin}), val_t'(0));
        check("rst_rsp_bus", val_t'({b0.rsp_sum, b0.rsp_cout}), val_t'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Both requesters valid from reset: grants alternate 0,1,0,1.
        exp_q.push_back('{1'b0, 64'h0000_0000_0000_0003, 1'b0});
        exp_q.push_back('{1'b1, 64'h2222_3333_4444_5555, 1'b0});
        exp_q.push_back('{1'b0, 64'h0000_0000_0000_0000, 1'b1});
        exp_q.push_back('{1'b1, 64'h0001_0000_0000_0000, 1'b0});
        fork
            stream2(1'b0, 64'h1, 64'h2, 64'hFFFF_0000_0000_0000, 64'h0001_0000_0000_0000);
            stream2(1'b1, 64'h1111_2222_3333_4444, 64'h1111_1111_1111_1111,
                          64'h0000_FFFF_FFFF_0000, 64'h0000_0000_0001_0000);
        join
        drain();

        // Carry into slice 1.
        exp_q.push_back('{1'b0, 64'h0000_0000_0001_0000, 1'b0});
        issue(1'b0, 64'h0000_0000_0000_FFFF, 64'h1);
        drain();

        // Ripple through every slice; carry-in seen on slices 1..3.
        exp_q.push_back('{1'b1, 64'h0, 1'b1});
        issue(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
        drain();
        check("cin_slices", val_t'(cin_log), val_t'(4'b1110));

        // Back-pressured response with a request waiting behind it.
        b0.rsp_ready = 1'b0;
        exp_q.push_back('{1'b0, 64'hC, 1'b0});
        issue(1'b0, 64'h5, 64'h7);
        exp_q.push_back('{1'b1, 64'h30, 1'b0});
        present(1'b1, 64'h10, 64'h20);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = b0.rsp_valid;
        end
        check("done_reached", val_t'(seen), val_t'(1));
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        b0.rsp_ready = 1'b1;
        await_accept(1'b1);
        @(posedge clk); #1;
        release_req(1'b1);
        check("accept_after_hs", val_t'(acc_cyc - hs_cyc), val_t'(1));
        drain();

        // Reset during the wait of slice 2 aborts without a response.
        issue(1'b0, 64'hABCD_0000_1111_2222, 64'h1);
        go_cnt = 0;
        for (int i = 0; i < 100 && go_cnt < 3; i++) begin
            @(negedge clk);
            if (b0.add_go) go_cnt++;
        end
        check("slice2_reached", val_t'(go_cnt), val_t'(3));
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("abort_add_bus", val_t'({b0.add_go, b0.add_a, b0.add_b, b0.add_cin}), val_t'(0));
        check("abort_rsp_bus", val_t'({b0.rsp_valid, b0.rsp_id, b0.rsp_cout, b0.req0_ready, b0.req1_ready}), val_t'(0));
        check("abort_rsp_sum", val_t'(b0.rsp_sum), val_t'(0));
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back('{1'b0, 64'h1235, 1'b0});
        issue(1'b0, 64'h1234, 64'h1);
        drain();

        // ADD_LAT=1 build.
        @(posedge clk); #1;
        b1.req0_valid = 1'b1;
        b1.req0_a = 64'h8000_0000_0000_0000;
        b1.req0_b = 64'h8000_0000_0000_0000;
        seen = 1'b0;
        acc1 = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = b1.req0_ready;
            acc1 = cyc;
        end
        check("lat1_accept", val_t'(seen), val_t'(1));
        @(posedge clk); #1;
        b1.req0_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = b1.rsp_valid;
        end
        check("lat1_done", val_t'(seen), val_t'(1));
        check("lat1_latency", val_t'(cyc - acc1), val_t'(9));
        check("lat1_sum", val_t'(b1.rsp_sum), val_t'(0));
        check("lat1_cout_id", val_t'({b1.rsp_cout, b1.rsp_id}), val_t'(2'b10));
        $display("[TB] rsp(lat1) id=%0d sum=0x%h cout=%0d", b1.rsp_id, b1.rsp_sum, b1.rsp_cout);
        @(posedge clk); #1;

        repeat (3) @(negedge clk);
        check("queue_empty", val_t'(exp_q.size()), val_t'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wide_add_sched.md
WIDE_ADD_SCHED -- requirements
Module: wide_add_sched

Interface
REQ-001 Parameter: W, 16, slice width of the shared carry-lookahead adder.
REQ-002 Parameter: NWORDS, 4, slices per operand; operand width N = W*NWORDS.
REQ-003 Parameter: ADD_LAT, 2, cycles from add_go to valid add_sum/add_cout (>=1).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req0_valid, req1_valid  in  1 each  requester has operands.
REQ-007 req0_ready, req1_ready  out  1 each  operands accepted this cycle.
REQ-008 req0_a, req0_b, req1_a, req1_b  in  N each  operands.
REQ-009 add_go  out  1  one-cycle issue strobe to shared adder.
REQ-010 add_a, add_b  out  W  current slice; add_cin  out  1  slice carry-in.
REQ-011 add_sum  in  W; add_cout  in  1  adder result, valid ADD_LAT cycles after add_go.
REQ-012 rsp_valid  out  1; rsp_ready  in  1  result handshake.
REQ-013 rsp_id  out  1 (requester served); rsp_sum  out  N; rsp_cout  out  1.

Function
REQ-014 FSM states IDLE, ISSUE, WAIT, DONE; reset state IDLE.
REQ-015 IDLE: at most one req*_ready high, only for the granted requester with valid high; accept = valid&ready; capture both operands, clear slice index k and carry, go to ISSUE.
REQ-016 Arbitration round-robin: one valid wins; both valid -> requester not served last wins; after reset requester 0 has priority.
REQ-017 A valid deasserted before ready is not accepted; no state change.
REQ-018 ISSUE (one cycle): add_go=1, add_a/add_b = operand bits [W*k+W-1 : W*k], add_cin = 0 for k=0 else stored carry; go to WAIT.
REQ-019 add_go, add_a, add_b, add_cin are 0 in every state except ISSUE.
REQ-020 WAIT lasts ADD_LAT cycles; in its last cycle sample add_sum into result slice k and add_cout into carry; k<NWORDS-1 -> k+1, ISSUE; else DONE.
REQ-021 Per-slice cost ADD_LAT+1 cycles; rsp_valid rises NWORDS*(ADD_LAT+1)+1 cycles after the accept cycle (13 with defaults).
REQ-022 DONE: rsp_valid=1; rsp_sum, rsp_cout, rsp_id held stable until rsp_valid&rsp_ready; then IDLE.
REQ-023 No request accepted in ISSUE, WAIT or DONE; both req*_ready low.
REQ-024 Arithmetic: rsp_sum = (a+b) mod 2^N; rsp_cout = carry out of slice NWORDS-1; no carry-in from requesters.
REQ-025 Accept in IDLE and response completion never overlap; one operation in flight.

Reset
REQ-026 rst asserted forces IDLE immediately, regardless of clk, aborting any operation without a response.
REQ-027 Reset values: all outputs 0; k, carry, operand and result registers 0; round-robin priority to requester 0.
REQ-028 Adder results arriving after a mid-operation reset are ignored.

Structure
REQ-029 Package wide_add_pkg holds the W/NWORDS/ADD_LAT defaults and the FSM state enum.
REQ-030 One sub-module: rr_arb2, two-input round-robin arbiter (req[1:0], accept strobe -> one-hot grant, last-winner register).
REQ-031 Shared adder is external; bench uses a behavioural W-bit adder with ADD_LAT registered stages.

Verification
REQ-032 req0 a=0x0000_0000_0000_FFFF b=0x1 -> rsp_sum=0x0000_0000_0001_0000, rsp_cout=0, rsp_id=0, rsp_valid 13 cycles after accept.
REQ-033 req1 a=0xFFFF_FFFF_FFFF_FFFF b=0x1 -> rsp_sum=0, rsp_cout=1, add_cin=1 on slices 1..3, rsp_id=1.
REQ-034 Both valid continuously from reset -> grants 0,1,0,1; each rsp_id matches; no double accept.
REQ-035 rsp_ready low 5 cycles in DONE -> rsp_* stable, both req*_ready 0; rsp_ready high -> IDLE next cycle, next accept following cycle.
REQ-036 rst pulsed during WAIT of slice 2 -> all outputs 0 immediately; next request a=0x1234, b=0x1 -> rsp_sum=0x1235, rsp_cout=0.
REQ-037 ADD_LAT=1 build, a=0x8000_0000_0000_0000 b=0x8000_0000_0000_0000 -> rsp_sum=0, rsp_cout=1, latency 9 cycles.
